// File: rtl/my_design_pkg.sv
// Shared constants for the convolution accelerator: SRAM geometry, FSM encoding and result clamping.
package my_design_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 20;

  localparam logic [15:0] TERMINATOR = 16'hFFFF;
  localparam logic [11:0] W_BASE     = 12'd0;
  localparam logic [11:0] O_BASE     = 12'd0;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD_W   = 3'd1;
  localparam logic [2:0] S_READ_HDR = 3'd2;
  localparam logic [2:0] S_FETCH    = 3'd3;
  localparam logic [2:0] S_COMPUTE  = 3'd4;
  localparam logic [2:0] S_WRITE    = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  function automatic logic [7:0] relu_sat8(input logic signed [ACC_W-1:0] v);
    if (v < 0)
      return 8'd0;
    else if (v > 20'sd127)
      return 8'd127;
    else
      return v[7:0];
  endfunction

endpackage

// File: rtl/conv_pool_unit.sv
// 3x3 signed MAC feeding a 2x2 running max; result is ReLU'd and clamped to 0..127.
// One convolution per cycle while vld is high; start restarts the max; no backpressure.
module conv_pool_unit (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic             vld,
  input  logic [8:0][7:0]  pix,
  input  logic [8:0][7:0]  wgt,
  output logic [7:0]       result
);
  import my_design_pkg::*;

  logic signed [ACC_W-1:0] conv;
  logic signed [ACC_W-1:0] max_q;
  logic signed [15:0]      prod [9];

  // 9 products of at most 2^14 in magnitude cannot overflow a 20-bit sum
  always_comb begin
    conv = '0;
    for (int i = 0; i < 9; i++) begin
      prod[i] = $signed(pix[i]) * $signed(wgt[i]);
      conv    = conv + ACC_W'(prod[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)
      max_q <= '0;
    else if (vld && (start || (conv > max_q)))
      max_q <= conv;
  end

  assign result = relu_sat8(max_q);

endmodule

// File: rtl/my_design.sv
// Convolution accelerator top: streams matrices from input SRAM, writes pooled results two per word.
// Roughly 14 cycles per pooled output (8 reads, 4 MACs, 1 pack); SRAMs never stall, no backpressure.
module my_design #(
  parameter int ADDR_W = my_design_pkg::ADDR_W,
  parameter int DATA_W = my_design_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              dut_run,
  output logic              dut_busy,

  output logic              input_sram_write_enable,
  output logic [ADDR_W-1:0] input_sram_write_addresss,
  output logic [DATA_W-1:0] input_sram_write_data,
  output logic [ADDR_W-1:0] input_sram_read_address,
  input  logic [DATA_W-1:0] input_sram_read_data,
  output logic [7:0]        data1,
  output logic [7:0]        data2,

  output logic              weights_sram_write_enable,
  output logic [ADDR_W-1:0] weights_sram_write_addresss,
  output logic [DATA_W-1:0] weights_sram_write_data,
  output logic [ADDR_W-1:0] weights_sram_read_address,
  input  logic [DATA_W-1:0] weights_sram_read_data,

  output logic              output_sram_write_enable,
  output logic [ADDR_W-1:0] output_sram_write_addresss,
  output logic [DATA_W-1:0] output_sram_write_data,
  output logic [ADDR_W-1:0] output_sram_read_address,
  input  logic [DATA_W-1:0] output_sram_read_data,

  output logic              scratchpad_sram_write_enable,
  output logic [ADDR_W-1:0] scratchpad_sram_write_addresss,
  output logic [DATA_W-1:0] scratchpad_sram_write_data,
  output logic [ADDR_W-1:0] scratchpad_sram_read_address,
  input  logic [DATA_W-1:0] scratchpad_sram_read_data
);
  import my_design_pkg::*;

  logic [2:0]              state;
  logic [3:0]              cnt;
  logic [ADDR_W-1:0]       hdr_addr;
  logic [ADDR_W-1:0]       out_ptr;
  logic [ADDR_W-1:0]       fetch_addr;
  logic [4:0]              n_dim;
  logic [3:0]              row_words;
  logic [2:0]              p_idx;
  logic [2:0]              q_idx;
  logic [2:0]              last_idx;
  logic [2:0]              k_idx;
  logic [3:0]              frow;
  logic                    last_win;
  logic [3:0][3:0][7:0]    win;
  logic [8:0][7:0]         wgt;
  logic [8:0][7:0]         pix9;
  logic [7:0]              res;
  logic [7:0]              hold_byte;
  logic                    half_full;
  logic                    unused_rd;

  assign input_sram_write_enable        = 1'b0;
  assign input_sram_write_addresss      = '0;
  assign input_sram_write_data          = '0;
  assign weights_sram_write_enable      = 1'b0;
  assign weights_sram_write_addresss    = '0;
  assign weights_sram_write_data        = '0;
  assign output_sram_read_address       = '0;
  assign scratchpad_sram_write_enable   = 1'b0;
  assign scratchpad_sram_write_addresss = '0;
  assign scratchpad_sram_write_data     = '0;
  assign scratchpad_sram_read_address   = '0;
  assign unused_rd = ^{output_sram_read_data, scratchpad_sram_read_data};

  assign dut_busy  = (state != S_IDLE);
  assign row_words = n_dim[4:1];
  assign last_idx  = 3'(row_words - 4'd2);
  assign last_win  = (p_idx == last_idx) && (q_idx == last_idx);
  assign k_idx     = 3'(cnt - 4'd1);

  // The 4x4 pixel window of pooled output (p,q) is words q and q+1 of rows 2p..2p+3
  assign frow       = {p_idx, 1'b0} + {2'b00, cnt[2:1]};
  assign fetch_addr = hdr_addr + ADDR_W'(1) + ADDR_W'(frow) * ADDR_W'(row_words)
                      + ADDR_W'(q_idx) + ADDR_W'(cnt[0]);

  always_comb begin
    input_sram_read_address   = '0;
    weights_sram_read_address = '0;
    case (state)
      S_LOAD_W:   weights_sram_read_address = ADDR_W'(W_BASE) + ADDR_W'(cnt);
      S_READ_HDR: input_sram_read_address   = hdr_addr;
      S_FETCH:    input_sram_read_address   = fetch_addr;
      default:    ;
    endcase
  end

  // cnt[1:0] selects which of the four convolutions in the 2x2 pool group is computed
  always_comb begin
    pix9 = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        pix9[3*i+j] = win[2'(i) + {1'b0, cnt[1]}][2'(j) + {1'b0, cnt[0]}];
  end

  conv_pool_unit u_cpu (
    .clk     (clk),
    .reset_b (reset_b),
    .start   (cnt == 4'd0),
    .vld     (state == S_COMPUTE),
    .pix     (pix9),
    .wgt     (wgt),
    .result  (res)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                      <= S_IDLE;
      cnt                        <= '0;
      hdr_addr                   <= '0;
      out_ptr                    <= '0;
      n_dim                      <= '0;
      p_idx                      <= '0;
      q_idx                      <= '0;
      win                        <= '0;
      wgt                        <= '0;
      hold_byte                  <= '0;
      half_full                  <= 1'b0;
      data1                      <= '0;
      data2                      <= '0;
      output_sram_write_enable   <= 1'b0;
      output_sram_write_addresss <= '0;
      output_sram_write_data     <= '0;
    end else begin
      output_sram_write_enable <= 1'b0;
      case (state)
        S_IDLE: begin
          if (dut_run) begin
            state     <= S_LOAD_W;
            cnt       <= '0;
            hdr_addr  <= '0;
            out_ptr   <= ADDR_W'(O_BASE);
            half_full <= 1'b0;
          end
        end
        S_LOAD_W: begin
          cnt <= cnt + 4'd1;
          if (cnt != 4'd0) begin
            wgt[{k_idx, 1'b0}] <= weights_sram_read_data[15:8];
            if (k_idx != 3'd4)
              wgt[{k_idx, 1'b1}] <= weights_sram_read_data[7:0];
          end
          if (cnt == 4'd5) begin
            state <= S_READ_HDR;
            cnt   <= '0;
          end
        end
        S_READ_HDR: begin
          if (cnt == 4'd0) begin
            cnt <= 4'd1;
          end else begin
            data1 <= input_sram_read_data[15:8];
            data2 <= input_sram_read_data[7:0];
            cnt   <= '0;
            if (input_sram_read_data == TERMINATOR) begin
              state <= S_DONE;
            end else begin
              n_dim <= input_sram_read_data[4:0];
              p_idx <= '0;
              q_idx <= '0;
              state <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          cnt <= cnt + 4'd1;
          if (cnt != 4'd0) begin
            win[k_idx[2:1]][{k_idx[0], 1'b0}] <= input_sram_read_data[15:8];
            win[k_idx[2:1]][{k_idx[0], 1'b1}] <= input_sram_read_data[7:0];
            data1 <= input_sram_read_data[15:8];
            data2 <= input_sram_read_data[7:0];
          end
          if (cnt == 4'd8) begin
            state <= S_COMPUTE;
            cnt   <= '0;
          end
        end
        S_COMPUTE: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd3) begin
            state <= S_WRITE;
            cnt   <= '0;
          end
        end
        S_WRITE: begin
          if (half_full || last_win) begin
            output_sram_write_enable   <= 1'b1;
            output_sram_write_addresss <= out_ptr;
            output_sram_write_data     <= half_full ? {hold_byte, res} : {res, 8'h00};
            out_ptr                    <= out_ptr + ADDR_W'(1);
            half_full                  <= 1'b0;
          end else begin
            hold_byte <= res;
            half_full <= 1'b1;
          end
          cnt <= '0;
          if (last_win) begin
            state    <= S_READ_HDR;
            hdr_addr <= hdr_addr + ADDR_W'(1) + ADDR_W'(row_words) * ADDR_W'(n_dim);
          end else begin
            state <= S_FETCH;
            if (q_idx == last_idx) begin
              q_idx <= '0;
              p_idx <= p_idx + 3'd1;
            end else begin
              q_idx <= q_idx + 3'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_my_design.sv
// Bench for my_design: SRAM models, directed and random jobs, reference model feeding a write scoreboard.
module tb_my_design;

  logic        clk = 1'b0;
  logic        reset_b = 1'b0;
  logic        dut_run = 1'b0;
  logic        dut_busy;
  logic        in_we, w_we, owe, sp_we;
  logic [11:0] in_waddr, w_waddr, oaddr, sp_waddr, sp_raddr, o_raddr;
  logic [15:0] in_wdata, w_wdata, odata, sp_wdata;
  logic [11:0] in_addr, w_addr;
  logic [15:0] in_rd = '0, w_rd = '0;
  logic [15:0] o_rd = '0, sp_rd = '0;
  logic [7:0]  data1, data2;

  logic [15:0] mem_in  [4096];
  logic [15:0] mem_w   [4096];
  logic [15:0] mem_out [4096];

  int checks = 0;
  int errors = 0;
  int wr_ptr = 0;
  logic [27:0] exp_q [$];
  logic [27:0] mon_e;

  always #5 clk = ~clk;

  my_design dut (
    .clk                            (clk),
    .reset_b                        (reset_b),
    .dut_run                        (dut_run),
    .dut_busy                       (dut_busy),
    .input_sram_write_enable        (in_we),
    .input_sram_write_addresss      (in_waddr),
    .input_sram_write_data          (in_wdata),
    .input_sram_read_address        (in_addr),
    .input_sram_read_data           (in_rd),
    .data1                          (data1),
    .data2                          (data2),
    .weights_sram_write_enable      (w_we),
    .weights_sram_write_addresss    (w_waddr),
    .weights_sram_write_data        (w_wdata),
    .weights_sram_read_address      (w_addr),
    .weights_sram_read_data         (w_rd),
    .output_sram_write_enable       (owe),
    .output_sram_write_addresss     (oaddr),
    .output_sram_write_data         (odata),
    .output_sram_read_address       (o_raddr),
    .output_sram_read_data          (o_rd),
    .scratchpad_sram_write_enable   (sp_we),
    .scratchpad_sram_write_addresss (sp_waddr),
    .scratchpad_sram_write_data     (sp_wdata),
    .scratchpad_sram_read_address   (sp_raddr),
    .scratchpad_sram_read_data      (sp_rd)
  );

  always @(posedge clk) begin
    in_rd <= mem_in[in_addr];
    w_rd  <= mem_w[w_addr];
    if (owe) mem_out[oaddr] <= odata;
  end

  task automatic chk(string name, int act, int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Scoreboard monitor: every output write must match the oldest expected {addr,data}
  always @(negedge clk) begin
    if (reset_b && owe) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr %0d data 0x%h", oaddr, odata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({oaddr, odata} !== mon_e) begin
          errors++;
          $display("FAIL out_word got addr %0d data 0x%h expected addr %0d data 0x%h",
                   oaddr, odata, mon_e[27:16], mon_e[15:0]);
        end
      end
    end
  end

  function automatic int sbyte(logic [15:0] w, int lo);
    logic signed [7:0] b;
    b = (lo != 0) ? w[7:0] : w[15:8];
    return int'(b);
  endfunction

  // Reference model: walks the record stream and computes conv/pool/clamp with plain integers
  task automatic expect_job();
    int a, n, np, optr, idx, s, best, v, w;
    int k [9];
    int px [16][16];
    int res [$];
    for (int i = 0; i < 9; i++) k[i] = sbyte(mem_w[i/2], i % 2);
    a = 0;
    optr = 0;
    while (mem_in[a] != 16'hFFFF && a < 4000) begin
      n = int'(mem_in[a]);
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) begin
          idx = r * n + c;
          px[r][c] = sbyte(mem_in[a + 1 + idx/2], idx % 2);
        end
      res.delete();
      np = (n - 2) / 2;
      for (int p = 0; p < np; p++)
        for (int q = 0; q < np; q++) begin
          best = -1000000;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              s = 0;
              for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                  s += px[2*p+dr+i][2*q+dc+j] * k[3*i+j];
              if (s > best) best = s;
            end
          v = (best < 0) ? 0 : (best > 127) ? 127 : best;
          res.push_back(v);
        end
      for (int i = 0; i < res.size(); i += 2) begin
        w = res[i] * 256 + ((i + 1 < res.size()) ? res[i+1] : 0);
        exp_q.push_back({12'(optr), 16'(w)});
        optr++;
      end
      a += 1 + n * n / 2;
    end
  endtask

  // kind 0: constant val, kind 1: pixel = its row-major index, kind 2: random
  task automatic put_rec(int n, int kind, int val);
    logic [7:0] b;
    int wa;
    mem_in[wr_ptr] = 16'(n);
    for (int idx = 0; idx < n * n; idx++) begin
      b  = (kind == 0) ? 8'(val) : (kind == 1) ? 8'(idx) : 8'($urandom);
      wa = wr_ptr + 1 + idx / 2;
      if (idx % 2 == 0) mem_in[wa][15:8] = b;
      else              mem_in[wa][7:0]  = b;
    end
    wr_ptr += 1 + n * n / 2;
  endtask

  task automatic put_term();
    mem_in[wr_ptr] = 16'hFFFF;
    wr_ptr = 0;
  endtask

  // kind 0: all val, kind 1: only centre tap = 1, kind 2: random
  task automatic set_w(int kind, int val);
    logic [7:0] b;
    for (int i = 0; i < 10; i++) begin
      b = (kind == 0) ? 8'(val) : (kind == 1) ? ((i == 4) ? 8'd1 : 8'd0) : 8'($urandom);
      if (i % 2 == 0) mem_w[i/2][15:8] = b;
      else            mem_w[i/2][7:0]  = b;
    end
  endtask

  task automatic run_job(string name);
    int i;
    expect_job();
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1;
    chk({name, "_busy_rise"}, int'(dut_busy), 1);
    repeat (2) @(posedge clk);
    #1 dut_run = 1'b0;
    i = 0;
    while (dut_busy && i < 20000) begin
      @(posedge clk);
      i++;
    end
    #1;
    chk({name, "_busy_fall"}, int'(dut_busy), 0);
    repeat (3) @(posedge clk);
    chk({name, "_pending_writes"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_in[i] = 16'hFFFF;
      mem_w[i] = '0;
      mem_out[i] = '0;
    end
    #12;
    chk("rst_busy", int'(dut_busy), 0);
    chk("rst_out_we", int'(owe), 0);
    chk("rst_out_addr", int'(oaddr), 0);
    chk("rst_out_data", int'(odata), 0);
    chk("rst_in_addr", int'(in_addr), 0);
    chk("rst_w_addr", int'(w_addr), 0);
    chk("rst_data1", int'(data1), 0);
    chk("rst_data2", int'(data2), 0);
    @(posedge clk); #1 reset_b = 1'b1;

    set_w(0, 1);    put_rec(4, 0, 1);   put_term(); run_job("ones");
    chk("ones_word0", int'(mem_out[0]), 16'h0900);
    set_w(0, 127);  put_rec(4, 0, 127); put_term(); run_job("sat");
    chk("sat_word0", int'(mem_out[0]), 16'h7F00);
    set_w(0, -1);   put_rec(4, 0, 1);   put_term(); run_job("relu");
    chk("relu_word0", int'(mem_out[0]), 16'h0000);
    set_w(1, 0);    put_rec(6, 1, 0);   put_term(); run_job("ramp");
    chk("ramp_word0", int'(mem_out[0]), 16'h0E10);
    chk("ramp_word1", int'(mem_out[1]), 16'h1A1C);

    set_w(0, 1); put_rec(4, 0, 1); put_rec(4, 0, 2); put_term();
    run_job("two_rec");
    chk("two_rec_word1", int'(mem_out[1]), 16'h1200);
    mem_out[0] = '0;
    mem_out[1] = '0;
    run_job("rerun");
    chk("rerun_word0", int'(mem_out[0]), 16'h0900);
    chk("rerun_word1", int'(mem_out[1]), 16'h1200);

    for (int j = 0; j < 4; j++) begin
      set_w(2, 0);
      for (int r = 0; r < int'($urandom_range(3, 1)); r++)
        put_rec(2 * int'($urandom_range(8, 2)), 2, 0);
      put_term();
      run_job("random");
    end

    set_w(2, 0); put_rec(16, 2, 0); put_term();
    expect_job();
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
    repeat (300) @(posedge clk);
    #3 reset_b = 1'b0;
    #1;
    chk("midrst_busy", int'(dut_busy), 0);
    chk("midrst_out_we", int'(owe), 0);
    chk("midrst_out_addr", int'(oaddr), 0);
    exp_q.delete();
    @(posedge clk); #1 reset_b = 1'b1;
    run_job("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
